dma_req_arb: RTL
================

Name: dma_req_arb

Overview:
- Shares one downstream DMA engine between NUM_REQ requesters.
- Each requester drives a dma requester bundle (req/addr/len/dack out; ack/dvld/d_last/data/be in). The engine side is a single acknowledger bundle.
- Round-robin arbitration picks one owner per transfer. The owner keeps the engine from request acceptance until its last data beat completes.
- Sits between the channel masters and the DMA engine inside the dma subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- AW, 32, address width.
- LW, 16, length width.
- DW, 32, data width; BEW = DW/8 is the byte-enable width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_req  in  NUM_REQ  per-requester request.
- s_addr  in  NUM_REQ*AW  per-requester address; slice i belongs to requester i.
- s_len  in  NUM_REQ*LW  per-requester length.
- s_dack  in  NUM_REQ  per-requester data acknowledge.
- s_ack  out  NUM_REQ  per-requester request acknowledge.
- s_dvld  out  NUM_REQ  per-requester data valid.
- s_d_last  out  NUM_REQ  per-requester last-beat flag.
- s_data  out  DW  read data, broadcast to all requesters.
- s_be  out  BEW  byte enables, broadcast to all requesters.
- m_req  out  1  request to the engine.
- m_addr  out  AW  address to the engine.
- m_len  out  LW  length to the engine.
- m_dack  out  1  data acknowledge to the engine.
- m_ack  in  1  engine request acknowledge.
- m_dvld  in  1  engine data valid.
- m_d_last  in  1  engine last-beat flag.
- m_data  in  DW  engine read data.
- m_be  in  BEW  engine byte enables.
- busy  out  1  high whenever state != IDLE.
- gnt_id  out  $clog2(NUM_REQ)  current owner index; valid while busy.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, gnt_id=0, m_req=0, m_addr=0, m_len=0. All s_ack, s_dvld and s_d_last are 0; m_dack=0; busy=0.
- Handshakes:
  - Request accepted when m_req & m_ack are high in the same cycle.
  - Data beat transfers when m_dvld & m_dack are high in the same cycle.
  - A requester holds s_req, addr and len stable until it sees s_ack.
- State IDLE:
  - If any s_req is set, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register gnt_id and go to REQ.
  - Arbitration latency is one cycle: m_req rises the cycle after s_req is first sampled.
- State REQ:
  - m_req=1; m_addr and m_len are muxed combinationally from requester gnt_id.
  - s_ack[gnt_id] = m_ack, combinational; all other s_ack are 0.
  - On acceptance, go to DATA.
  - If s_req[gnt_id] drops before acceptance (protocol violation), return to IDLE with no pointer update.
- State DATA:
  - m_req=0.
  - s_dvld[gnt_id] = m_dvld and s_d_last[gnt_id] = m_d_last; all other lanes are 0.
  - m_dack = s_dack[gnt_id].
  - s_data and s_be pass through unregistered.
  - On a beat with m_d_last=1: go to IDLE and set rr_ptr = gnt_id+1, wrapping to 0 at NUM_REQ.
- Outside DATA, m_dack=0 and every s_dvld is 0; engine data arriving then is not forwarded.
- Requests seen while busy wait; they are not dropped.
- IDLE to IDLE is one dead cycle per transfer; no back-to-back pipelining.
- Simultaneous requests: the round-robin pointer guarantees each active requester is granted within NUM_REQ transfers.
- len is forwarded unchanged; len=0 semantics belong to the engine.
- Reset asserted mid-transfer forces all outputs to reset values immediately; the engine is reset by the same rst_n.

Optional Feature:
- Macro DMA_ARB_WDOG_EN.
- When defined:
  - A 16-bit counter clears on entering DATA and on every beat, and increments in DATA while m_dvld=0.
  - At 0xFFFF the block forces IDLE, advances rr_ptr, and pulses a new output port wdog_err (1 bit, reset 0) for exactly one cycle.
- When undefined: no counter, no wdog_err port; DATA waits indefinitely for d_last.

Decomposition:
- Package dma_pkg holds:
  - arb_state_e enum {IDLE, REQ, DATA};
  - localparams DMA_AW=32, DMA_LW=16, DMA_DW=32;
  - WDOG_MAX=16'hFFFF.
- One sub-module, dma_rr_pick: combinational round-robin picker (req vector plus pointer in; index and found out). It is reusable by other arbiters.

Test Plan:
- Single requester: s_req[2]=1, addr=0x1000, len=4; engine acks on cycle 3, returns 4 beats with the last flagged. Required: m_req high from cycle 1; s_ack[2] mirrors m_ack; 4 s_dvld[2] pulses; busy drops the cycle after the last beat; rr_ptr=3.
- All four requesting continuously, 1 beat each: grant order 0,1,2,3,0. No requester sees s_dvld while not the owner.
- Backpressure: owner s_dack=0 for 5 cycles with m_dvld=1. Required: m_dack=0, no beat counted, still in DATA. Then dack=1 and the transfer completes.
- Stray engine data in IDLE (m_dvld=1): all s_dvld stay 0, m_dack=0.
- rst_n low mid-DATA on beat 2 of 8: all outputs 0 asynchronously; after release rr_ptr=0 and a fresh arbitration occurs.
- DMA_ARB_WDOG_EN defined, engine stalls in DATA for 65535 cycles: wdog_err pulses once, state returns to IDLE, the next requester is granted.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA subsystem arbiters.
// The optional DMA_ARB_WDOG_EN watchdog uses WDOG_MAX as its stall limit.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam int DMA_AW = 32;
  localparam int DMA_LW = 16;
  localparam int DMA_DW = 32;

  localparam logic [15:0] WDOG_MAX = 16'hFFFF;

  // Next round-robin index after id, wrapping to 0 at n.
  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching upward
// from ptr_i, wrapping modulo N. found_o is low when req_i is all zero.
module dma_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  int cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/dma_req_arb.sv
// Round-robin sharing of one DMA engine between NUM_REQ requesters; the owner
// holds the engine from request acceptance to its last beat. Optional watchdog: DMA_ARB_WDOG_EN.
module dma_req_arb
  import dma_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = DMA_AW,
  parameter int LW      = DMA_LW,
  parameter int DW      = DMA_DW,
  parameter int BEW     = DW / 8,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    s_req,
  input  logic [NUM_REQ*AW-1:0] s_addr,
  input  logic [NUM_REQ*LW-1:0] s_len,
  input  logic [NUM_REQ-1:0]    s_dack,
  output logic [NUM_REQ-1:0]    s_ack,
  output logic [NUM_REQ-1:0]    s_dvld,
  output logic [NUM_REQ-1:0]    s_d_last,
  output logic [DW-1:0]         s_data,
  output logic [BEW-1:0]        s_be,
  output logic                  m_req,
  output logic [AW-1:0]         m_addr,
  output logic [LW-1:0]         m_len,
  output logic                  m_dack,
  input  logic                  m_ack,
  input  logic                  m_dvld,
  input  logic                  m_d_last,
  input  logic [DW-1:0]         m_data,
  input  logic [BEW-1:0]        m_be,
`ifdef DMA_ARB_WDOG_EN
  output logic                  wdog_err,
`endif
  output logic                  busy,
  output logic [IW-1:0]         gnt_id,
  output arb_state_e            dbg_state,
  output logic [IW-1:0]         dbg_rr_ptr
);

  // Handshakes: a request is accepted in a cycle with m_req & m_ack high; a
  // data beat moves in a cycle with m_dvld & m_dack high. Requesters hold
  // s_req/addr/len stable until they see s_ack.

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] rr_inc;
  logic          beat;

  dma_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (s_req),
    .ptr_i   (rr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign rr_inc = IW'(rr_next(int'(gnt_q), NUM_REQ));
  assign beat   = m_dvld & m_dack;

`ifdef DMA_ARB_WDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        wd_timeout;

  assign wd_timeout = (state_q == DATA) && (wd_q == WDOG_MAX);
  assign wdog_err   = wd_timeout;

  always_comb begin
    wd_d = wd_q;
    if (state_q == REQ && state_d == DATA) begin
      wd_d = '0;
    end else if (state_q == DATA) begin
      if (beat)         wd_d = '0;
      else if (!m_dvld) wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        // Acceptance wins over a same-cycle request drop: the engine took it.
        if (m_ack)               state_d = DATA;
        else if (!s_req[gnt_q])  state_d = IDLE;
      end
      DATA: begin
        if (beat && m_d_last) begin
          state_d = IDLE;
          rr_d    = rr_inc;
        end
`ifdef DMA_ARB_WDOG_EN
        if (wd_timeout) begin
          state_d = IDLE;
          rr_d    = rr_inc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_req    = 1'b0;
    m_addr   = '0;
    m_len    = '0;
    m_dack   = 1'b0;
    s_ack    = '0;
    s_dvld   = '0;
    s_d_last = '0;
    case (state_q)
      REQ: begin
        m_req        = 1'b1;
        m_addr       = s_addr[int'(gnt_q)*AW +: AW];
        m_len        = s_len[int'(gnt_q)*LW +: LW];
        s_ack[gnt_q] = m_ack;
      end
      DATA: begin
        s_dvld[gnt_q]   = m_dvld;
        s_d_last[gnt_q] = m_d_last;
        m_dack          = s_dack[gnt_q];
      end
      default: ;
    endcase
  end

  assign s_data     = m_data;
  assign s_be       = m_be;
  assign busy       = (state_q != IDLE);
  assign gnt_id     = gnt_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_q;

endmodule
